// File: rtl/stopwatch_core.sv
// stopwatch_core: H:MM:SS stopwatch with built-in 1 s prescaler; optional lap hold via STOPWATCH_LAP_HOLD_EN
module stopwatch_core #(
  parameter int TICK_DIV = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       startstop,
  input  logic       clear,
  input  logic       lap,
  output logic [6:0] s0,
  output logic [6:0] s1,
  output logic [6:0] m0,
  output logic [6:0] m1,
  output logic [6:0] h,
  output logic       running,
  output logic       held,
  output logic       wrap
);
  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  typedef enum logic [1:0] {STOP, RUN, PAUSE} state_t;
  state_t state;
  logic [PW-1:0] pre;
  logic [6:0] d_s0, d_s1, d_m0, d_m1, d_h;
  logic [34:0] live;
  logic step, c0, c1, c2, c3, c4;
  assign step = (state == RUN) && (pre == PW'(TICK_DIV - 1));
  assign c0 = step && d_s0 == 7'd9;
  assign c1 = c0 && d_s1 == 7'd5;
  assign c2 = c1 && d_m0 == 7'd9;
  assign c3 = c2 && d_m1 == 7'd5;
  assign c4 = c3 && d_h == 7'd9;
  assign live = {d_h, d_m1, d_m0, d_s1, d_s0};
  // run/pause FSM, prescaler and the per-digit carry chain, all decided on the pre-edge state
  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      state   <= STOP;
      running <= 1'b0;
      pre     <= '0;
      d_s0    <= '0;
      d_s1    <= '0;
      d_m0    <= '0;
      d_m1    <= '0;
      d_h     <= '0;
      wrap    <= 1'b0;
    end else begin
      if (startstop) begin
        state   <= (state == RUN) ? PAUSE : RUN;
        running <= state != RUN;
      end
      if (state == RUN) pre <= step ? '0 : pre + 1'b1;
      if (step) d_s0 <= c0 ? 7'd0 : d_s0 + 7'd1;
      if (c0) d_s1 <= c1 ? 7'd0 : d_s1 + 7'd1;
      if (c1) d_m0 <= c2 ? 7'd0 : d_m0 + 7'd1;
      if (c2) d_m1 <= c3 ? 7'd0 : d_m1 + 7'd1;
      if (c3) d_h <= c4 ? 7'd0 : d_h + 7'd1;
      wrap <= c4;
    end
  end
`ifdef STOPWATCH_LAP_HOLD_EN
  logic [34:0] snap;
  // lap freezes a snapshot of the live digits while running; a second lap releases it
  always_ff @(posedge clk) begin
    if (!rst) begin
      held <= 1'b0;
      snap <= '0;
    end else if (clear) begin
      held <= 1'b0;
    end else if (lap && held) begin
      held <= 1'b0;
    end else if (lap && state == RUN) begin
      held <= 1'b1;
      snap <= live;
    end
  end
  assign {h, m1, m0, s1, s0} = held ? snap : live;
`else
  logic unused_lap;
  assign unused_lap = lap;
  assign held = 1'b0;
  assign {h, m1, m0, s1, s0} = live;
`endif
endmodule

// File: tb/tb_stopwatch_core.sv
// tb_stopwatch_core: randomized and directed checks of stopwatch_core against a seconds-count model
module tb_stopwatch_core;
  // TICK_DIV=2 keeps the full ten-hour rollover inside the cycle budget
  localparam int TD = 2;
`ifdef STOPWATCH_LAP_HOLD_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b0, startstop = 1'b0, clear = 1'b0, lap = 1'b0;
  logic [6:0] s0, s1, m0, m1, h;
  logic running, held, wrap;
  int errors = 0, checks = 0;
  int m_secs = 0, m_sub = 0, m_snap = 0;
  bit m_run = 0, m_held = 0, m_wrap = 0;
  logic [34:0] frozen;

  stopwatch_core #(.TICK_DIV(TD)) dut (
    .clk(clk), .rst(rst), .startstop(startstop), .clear(clear), .lap(lap),
    .s0(s0), .s1(s1), .m0(m0), .m1(m1), .h(h),
    .running(running), .held(held), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [34:0] digits(input int s);
    return {7'(s / 3600), 7'((s / 600) % 6), 7'((s / 60) % 10), 7'((s / 10) % 6), 7'(s % 10)};
  endfunction

  // one clock: apply inputs, advance the model by the stopwatch rules, compare every output
  task automatic cyc(input bit r, input bit ss, input bit cl, input bit lp);
    bit stp;
    rst = r; startstop = ss; clear = cl; lap = lp;
    @(posedge clk);
    if (!r) begin
      m_run = 0; m_sub = 0; m_secs = 0; m_held = 0; m_snap = 0; m_wrap = 0;
    end else if (cl) begin
      m_run = 0; m_sub = 0; m_secs = 0; m_held = 0; m_wrap = 0;
    end else begin
      stp = m_run && m_sub == TD - 1;
      if (LAP_EN && lp) begin
        if (m_held) m_held = 0;
        else if (m_run) begin m_held = 1; m_snap = m_secs; end
      end
      m_wrap = stp && m_secs == 35999;
      if (m_run) m_sub = stp ? 0 : m_sub + 1;
      if (stp) m_secs = (m_secs + 1) % 36000;
      if (ss) m_run = !m_run;
    end
    #1;
    check("out", {h, m1, m0, s1, s0, running, held, wrap},
          {digits(m_held ? m_snap : m_secs), m_run, m_held, m_wrap});
  endtask

  initial begin
    repeat (3) cyc(0, 1'($urandom), 1'($urandom), 1'($urandom));
    check("reset", {h, m1, m0, s1, s0, running, held, wrap}, 0);

    cyc(1, 1, 0, 0);
    repeat (10 * TD) cyc(1, 0, 0, 0);
    check("t2_s1", s1, 1);
    check("t2_s0", s0, 0);
    check("t2_run", running, 1);

    for (int i = 0; i < 4 * TD && m_sub != 1; i++) cyc(1, 0, 0, 0);
    cyc(1, 1, 0, 0);
    frozen = {h, m1, m0, s1, s0};
    repeat (100) cyc(1, 0, 0, 0);
    check("t3_frozen", {h, m1, m0, s1, s0}, frozen);
    check("t3_paused", running, 0);
    cyc(1, 1, 0, 0);
    repeat (TD - m_sub - 1) cyc(1, 0, 0, 0);
    check("t3_hold_to_step", {h, m1, m0, s1, s0}, frozen);
    cyc(1, 0, 0, 0);
    check("t3_step", {h, m1, m0, s1, s0}, digits(m_secs));

    for (int i = 0; i < 80000 && m_secs != 35999; i++) cyc(1, 0, 0, 0);
    check("t4_max", {h, m1, m0, s1, s0}, {7'd9, 7'd5, 7'd9, 7'd5, 7'd9});
    for (int i = 0; i < TD && !m_wrap; i++) cyc(1, 0, 0, 0);
    check("t4_zero", {h, m1, m0, s1, s0}, 0);
    check("t4_wrap", wrap, 1);
    check("t4_run", running, 1);
    cyc(1, 0, 0, 0);
    check("t4_wrap_once", wrap, 0);

    for (int i = 0; i < 4 * TD && !(m_run && m_sub == TD - 1); i++) cyc(1, 0, 0, 0);
    cyc(1, 1, 1, 0);
    check("t5_zero", {h, m1, m0, s1, s0, running}, 0);
    cyc(1, 1, 0, 0);
    repeat (TD - 1) cyc(1, 0, 0, 0);
    check("t5_nostep", s0, 0);
    cyc(1, 0, 0, 0);
    check("t5_first", s0, 1);

    cyc(1, 0, 1, 0);
    cyc(1, 1, 0, 0);
    repeat (5 * TD) cyc(1, 0, 0, 0);
    check("t6_at5", s0, 5);
    cyc(1, 0, 0, 1);
    check("t6_held", held, LAP_EN);
    repeat (5 * TD - 2) cyc(1, 0, 0, 0);
    check("t6_shown", s0, LAP_EN ? 5 : 9);
    cyc(1, 0, 0, 1);
    check("t6_release", {held, m1, m0, s1, s0}, {1'b0, 7'd0, 7'd0, 7'd1, 7'd0});

    repeat (600) cyc(($urandom % 100) != 0, ($urandom % 8) == 0, ($urandom % 40) == 0, ($urandom % 8) == 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
